// File: rtl/ground_query_arbiter.sv
// Round-robin arbiter that shares the ground/platform table between requesters and scans it one entry per cycle.
// Optional build macro GROUND_QUERY_EARLY_EXIT_EN: stop the scan at the first zero-length entry.
module ground_query_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_ENT = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [29*NUM_ENT-1:0]  info_ground,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [10*NUM_REQ-1:0]  q_x,
    input  logic [6*NUM_REQ-1:0]   q_w,
    input  logic [9*NUM_REQ-1:0]   q_y,
    input  logic [5*NUM_REQ-1:0]   q_dy,
    output logic [NUM_REQ-1:0]     done,
    output logic                   hit,
    output logic [8:0]             ground_y,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    localparam int IDX_W     = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
    localparam int ENT_SLOTS = 1 << IDX_W;
    localparam int ENT_BITS  = 29 * ENT_SLOTS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
    endfunction

    state_t             state_r, state_nxt_s;
    logic [2:0]         rr_r, grant_r, pick_s;
    logic [IDX_W-1:0]   idx_r;
    logic [9:0]         lx_r;
    logic [5:0]         lw_r;
    logic [8:0]         ly_r;
    logic [4:0]         ldy_r;
    logic               best_valid_r;
    logic [8:0]         best_y_r;
    logic [NUM_REQ-1:0] done_r, done_hot_s;
    logic               hit_r, busy_r;
    logic [8:0]         ground_y_r;

    logic               any_req_s;
    logic [2*NUM_REQ-1:0] rot_s;
    logic [79:0]        qx_pad_s;
    logic [47:0]        qw_pad_s;
    logic [71:0]        qy_pad_s;
    logic [39:0]        qdy_pad_s;
    logic [ENT_BITS-1:0] ent_pad_s;
    logic [9:0]         qx_a  [0:7];
    logic [5:0]         qw_a  [0:7];
    logic [8:0]         qy_a  [0:7];
    logic [4:0]         qdy_a [0:7];
    logic [9:0]         ex_a  [0:ENT_SLOTS-1];
    logic [8:0]         ey_a  [0:ENT_SLOTS-1];
    logic [9:0]         el_a  [0:ENT_SLOTS-1];

    logic [9:0]         ex_s, el_s;
    logic [8:0]         ey_s;
    logic [5:0]         w_eff_s;
    logic [10:0]        e_right_s, q_right_s;
    logic [9:0]         y_reach_s;
    logic               overlap_s, reach_s, cand_s, better_s, last_s;
    logic               nb_valid_s;
    logic [8:0]         nb_y_s;

    // Unpack the flat port buses into indexable arrays padded to a power-of-two depth.
    always_comb begin
        qx_pad_s  = 80'(q_x);
        qw_pad_s  = 48'(q_w);
        qy_pad_s  = 72'(q_y);
        qdy_pad_s = 40'(q_dy);
        ent_pad_s = ENT_BITS'(info_ground);
        for (int i = 0; i < 8; i++) begin
            qx_a[i]  = qx_pad_s[i*10 +: 10];
            qw_a[i]  = qw_pad_s[i*6 +: 6];
            qy_a[i]  = qy_pad_s[i*9 +: 9];
            qdy_a[i] = qdy_pad_s[i*5 +: 5];
        end
        for (int e = 0; e < ENT_SLOTS; e++) begin
            ex_a[e] = ent_pad_s[e*29 +: 10];
            ey_a[e] = ent_pad_s[e*29+10 +: 9];
            el_a[e] = ent_pad_s[e*29+19 +: 10];
        end
    end

    // Round-robin pick: rotate so the rr pointer is bit 0, lowest set offset wins.
    always_comb begin
        any_req_s = 1'b0;
        pick_s    = 3'd0;
        rot_s     = {req, req} >> rr_r;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                any_req_s = 1'b1;
                pick_s    = wrap_add(rr_r, 3'(i));
            end else begin
                any_req_s = any_req_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            done_hot_s[i] = (grant_r == 3'(i));
        end
    end

    // Evaluate the current table entry against the latched query; all sums widened to avoid wrap.
    always_comb begin
        ex_s      = ex_a[idx_r];
        ey_s      = ey_a[idx_r];
        el_s      = el_a[idx_r];
        w_eff_s   = (lw_r == 6'd0) ? 6'd1 : lw_r;
        e_right_s = {1'b0, ex_s} + {1'b0, el_s};
        q_right_s = {1'b0, lx_r} + {5'd0, w_eff_s} - 11'd1;
        y_reach_s = {1'b0, ly_r} + {5'd0, ldy_r};
        overlap_s = ({1'b0, lx_r} <= e_right_s) && (q_right_s >= {1'b0, ex_s});
        reach_s   = (ly_r <= ey_s) && ({1'b0, ey_s} <= y_reach_s);
        cand_s    = (el_s != 10'd0) && overlap_s && reach_s;
        better_s  = cand_s && (!best_valid_r || (ey_s < best_y_r));
        nb_valid_s = best_valid_r | cand_s;
        nb_y_s    = better_s ? ey_s : best_y_r;
`ifdef GROUND_QUERY_EARLY_EXIT_EN
        last_s    = (el_s == 10'd0) || (idx_r == LAST_IDX);
`else
        last_s    = (idx_r == LAST_IDX);
`endif
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, query latches, best-so-far and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            rr_r         <= 3'd0;
            grant_r      <= 3'd0;
            idx_r        <= '0;
            lx_r         <= 10'd0;
            lw_r         <= 6'd0;
            ly_r         <= 9'd0;
            ldy_r        <= 5'd0;
            best_valid_r <= 1'b0;
            best_y_r     <= 9'd0;
            done_r       <= '0;
            hit_r        <= 1'b0;
            ground_y_r   <= 9'd0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r      <= pick_s;
                        lx_r         <= qx_a[pick_s];
                        lw_r         <= qw_a[pick_s];
                        ly_r         <= qy_a[pick_s];
                        ldy_r        <= qdy_a[pick_s];
                        best_valid_r <= 1'b0;
                        best_y_r     <= 9'd0;
                        idx_r        <= '0;
                    end
                end
                ST_SCAN: begin
                    best_valid_r <= nb_valid_s;
                    best_y_r     <= nb_y_s;
                    idx_r        <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        done_r <= done_hot_s;
                        hit_r  <= nb_valid_s;
                        if (nb_valid_s) begin
                            ground_y_r <= nb_y_s;
                        end
                    end
                end
                ST_DONE: begin
                    rr_r <= wrap_add(grant_r, 3'd1);
                end
                default: begin
                    rr_r <= rr_r;
                end
            endcase
        end
    end

    assign done     = done_r;
    assign hit      = hit_r;
    assign ground_y = ground_y_r;
    assign busy     = busy_r;
    assign grant_id = grant_r;

endmodule

// File: doc/ground_query_arbiter.md
Name: ground_query_arbiter

Overview:
- Shares the 16-entry ground/platform table between several requesters (player, enemies). Each requester asks: "is there ground under my feet within the next dy pixels?"
- Round-robin arbitration grants one query at a time. The FSM scans the table one entry per cycle and returns hit plus the highest reachable surface.
- Sits between the world-map table output and the per-character motion logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_ENT, 16, number of table entries scanned

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- info_ground  in  29 x NUM_ENT  packed entries: [9:0] x_start, [18:10] y_loc, [28:19] length
- req  in  NUM_REQ  query request per requester, level, held until matching done
- q_x  in  10 x NUM_REQ  hitbox left x
- q_w  in  6 x NUM_REQ  hitbox width, 1..63
- q_y  in  9 x NUM_REQ  current feet y
- q_dy  in  5 x NUM_REQ  fall distance this frame, 0..31
- done  out  NUM_REQ  one-cycle, one-hot completion pulse to the granted requester
- hit  out  1  result: surface found
- ground_y  out  9  result: surface y (valid when hit)
- busy  out  1  high in SCAN and DONE
- grant_id  out  3  index of the requester being served

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; scan index 0; best-so-far cleared.
- Reset is synchronous and overrides everything. A reset mid-scan aborts the query: no done pulse, and the requester is re-arbitrated after reset.
- FSM:
  - IDLE: if any req, pick the first set bit searching from rr pointer upward with wrap. Latch that requester's q_x/q_w/q_y/q_dy into internal registers, set grant_id, clear best, idx=0, go SCAN. Otherwise stay in IDLE.
  - SCAN: evaluate entry idx each cycle. After idx=NUM_ENT-1, go DONE.
  - DONE: assert done[grant_id]=1 and update hit/ground_y for one cycle. Set rr pointer = grant_id+1 (mod NUM_REQ). Go IDLE.
- Latency: req sampled in IDLE cycle 0; SCAN cycles 1..16; done in cycle 17. At least one IDLE cycle follows, so max throughput is 1 query per 18 cycles.
- Query inputs are latched at grant; later changes are ignored until the next grant.
- Entry validity: length != 0. Zero-length entries are skipped.
- Horizontal overlap:
  - Entry spans x_start..x_start+length inclusive; query spans q_x..q_x+q_w-1.
  - Overlap iff q_x <= x_start+length AND q_x+q_w-1 >= x_start.
  - All sums computed at 11 bits, no truncation.
- Vertical reach: q_y <= y_loc <= q_y+q_dy, sums at 10 bits.
- Candidate = valid AND horizontal overlap AND vertical reach.
- Best candidate is the smallest y_loc. On equal y_loc, the lower index wins (strict < compare).
- hit/ground_y hold their value from DONE until the next DONE; they are not cleared in IDLE.
- A requester dropping req mid-scan does not abort; done still pulses.
- req remains high after done: re-eligible in the next IDLE, with round-robin order applied.
- q_w=0 is treated as width 1.

Optional Feature:
- Macro GROUND_QUERY_EARLY_EXIT_EN.
- Defined:
  - The table is terminated by its first zero-length entry. SCAN hitting such an entry goes directly to DONE next cycle, evaluating no further entries.
  - Latency becomes (index of first zero-length entry)+2 cycles after grant, or full latency if none.
- Undefined: always scan all NUM_ENT entries; zero-length entries are skipped.

Test Plan:
- Table {0,410,639},{500,310,139},{70,200,220},{320,250,40}, rest 0. req[0] with x=100,w=20,y=195,dy=8 -> done[0] in cycle 17, hit=1, ground_y=200.
- Same table. req[1] with x=550,w=20,y=300,dy=15 -> hit=1, ground_y=310. Then x=300,w=10,y=240,dy=20 -> hit=0, ground_y stays 310.
- Overlapping candidates: entries {0,300,639} and {0,305,639}, query y=298,dy=10 -> ground_y=300. Duplicate y_loc at idx 2 and 5 -> result identical, lower index wins.
- req[0] and req[2] held continuously after reset -> done order 0,2,0,2, with each done spaced 18 cycles.
- Assert Reset at SCAN cycle 8 -> no done, outputs 0. Request re-served after reset with a full 17-cycle latency.
- With GROUND_QUERY_EARLY_EXIT_EN and the 4-entry table above -> done in cycle 6 after grant, results identical to the full-scan build.
